// File: rtl/pipe_pkg.sv
// Shared pipeline constants and next-PC op encodings used by the fetch stage and ID/EX.
package pipe_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] BUBBLE_INSTR     = 32'hfedc_ba98;
    localparam logic [31:0] PC_STEP          = 32'd4;

    // Same encoding as the ID/EX npcop field.
    typedef enum logic [1:0] {
        NPC_SEQ    = 2'b00,
        NPC_BRANCH = 2'b01,
        NPC_JUMP   = 2'b10,
        NPC_JR     = 2'b11
    } npc_op_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry hold register that absorbs IF/ID stalls, plus the mux choosing what
// the fetch stage presents this cycle.
module fetch_skid_buffer #(
    parameter logic [31:0] BUBBLE_INSTR = pipe_pkg::BUBBLE_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        resp_valid,
    input  logic [31:0] resp_pc,
    input  logic [31:0] resp_data,
    input  logic        ifid_write,
    input  logic        redirect_valid,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic        fetch_valid,
    output logic        out_valid
);

    logic        hold_valid_q;
    logic [31:0] hold_pc_q;
    logic [31:0] hold_instr_q;

    assign out_valid = hold_valid_q | resp_valid;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid_q <= 1'b0;
            hold_pc_q    <= BUBBLE_INSTR;
            hold_instr_q <= BUBBLE_INSTR;
        end else if (redirect_valid) begin
            hold_valid_q <= 1'b0;
        end else if (resp_valid && !hold_valid_q && !ifid_write) begin
            // Memory data is only valid in the response cycle, so it must be captured now.
            hold_valid_q <= 1'b1;
            hold_pc_q    <= resp_pc;
            hold_instr_q <= resp_data;
        end else if (hold_valid_q && ifid_write) begin
            hold_valid_q <= 1'b0;
        end
    end

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        fetch_valid     = 1'b0;
        pc_out          = BUBBLE_INSTR;
        instruction_out = BUBBLE_INSTR;
        if (reset || redirect_valid) begin
            fetch_valid = 1'b0;
        end else if (hold_valid_q) begin
            fetch_valid     = 1'b1;
            pc_out          = hold_pc_q;
            instruction_out = hold_instr_q;
        end else if (resp_valid) begin
            fetch_valid     = 1'b1;
            pc_out          = resp_pc;
            instruction_out = resp_data;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, issues 1-cycle-latency imem reads,
// and presents pc/instruction/valid to the IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC     = pipe_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] BUBBLE_INSTR = pipe_pkg::BUBBLE_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ifid_write,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic        fetch_valid
);
    import pipe_pkg::*;

    logic [31:0] pc_q;
    logic        resp_valid_q;
    logic [31:0] resp_pc_q;
    logic        out_valid;

    // A new request is safe whenever the presented slot will be consumed or is empty.
    assign imem_en   = !reset && !redirect_valid && (ifid_write || !out_valid);
    assign imem_addr = pc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            resp_valid_q <= 1'b0;
            resp_pc_q    <= BUBBLE_INSTR;
        end else if (redirect_valid) begin
            pc_q         <= word_align(redirect_pc);
            resp_valid_q <= 1'b0;
        end else if (imem_en) begin
            pc_q         <= pc_q + PC_STEP;
            resp_valid_q <= 1'b1;
            resp_pc_q    <= pc_q;
        end else begin
            resp_valid_q <= 1'b0;
        end
    end

    fetch_skid_buffer #(
        .BUBBLE_INSTR(BUBBLE_INSTR)
    ) u_skid (
        .clk            (clk),
        .reset          (reset),
        .resp_valid     (resp_valid_q),
        .resp_pc        (resp_pc_q),
        .resp_data      (imem_rdata),
        .ifid_write     (ifid_write),
        .redirect_valid (redirect_valid),
        .pc_out         (pc_out),
        .instruction_out(instruction_out),
        .fetch_valid    (fetch_valid),
        .out_valid      (out_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a random stall/redirect
// run, compared against a slot-level model of the fetch stream.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] BUBBLE   = 32'hfedc_ba98;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ifid_write = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        fetch_valid;

    int    tests = 0;
    int    fails = 0;
    string phase = "init";

    // Model: the fetch stream is a next-fetch address plus at most one presented item.
    logic [31:0] m_fetch_pc   = RESET_PC;
    logic        m_slot_valid = 1'b0;
    logic [31:0] m_slot_pc    = 32'h0;
    logic        prev_en      = 1'b0;
    logic [31:0] prev_addr    = 32'h0;

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .ifid_write     (ifid_write),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .pc_out         (pc_out),
        .instruction_out(instruction_out),
        .fetch_valid    (fetch_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return {pc[15:0], ~pc[15:0]} ^ 32'h1357_9bdf;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s/%s: got %08h, expected %08h at %0t", phase, tag, got, exp, $time);
        end
    endtask

    // Hold and response registers must never both be occupied.
    always @(negedge clk) begin
        if (!reset) begin
            hold_resp_excl: assert (!(dut.u_skid.hold_valid_q && dut.resp_valid_q))
                else $error("hold and resp both valid");
            check("hold_resp_excl", {31'b0, dut.u_skid.hold_valid_q & dut.resp_valid_q}, 32'h0);
        end
    end

    // One clock cycle: drive inputs, check outputs at negedge, advance the model.
    task automatic step(input logic rst, input logic w, input logic r, input logic [31:0] rp);
        logic        exp_en;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        reset          = rst;
        ifid_write     = w;
        redirect_valid = r;
        redirect_pc    = rp;
        imem_rdata     = prev_en ? mem_word(prev_addr) : $urandom();
        @(negedge clk);
        if (rst) begin
            exp_en    = 1'b0;
            exp_valid = 1'b0;
            exp_pc    = BUBBLE;
            exp_instr = BUBBLE;
        end else begin
            exp_en    = !r && (w || !m_slot_valid);
            exp_valid = !r && m_slot_valid;
            exp_pc    = exp_valid ? m_slot_pc : BUBBLE;
            exp_instr = exp_valid ? mem_word(m_slot_pc) : BUBBLE;
            check("imem_addr", imem_addr, m_fetch_pc);
        end
        check("imem_en", {31'b0, imem_en}, {31'b0, exp_en});
        check("fetch_valid", {31'b0, fetch_valid}, {31'b0, exp_valid});
        check("pc_out", pc_out, exp_pc);
        check("instruction_out", instruction_out, exp_instr);
        prev_en   = exp_en;
        prev_addr = m_fetch_pc;
        if (rst) begin
            m_fetch_pc   = RESET_PC;
            m_slot_valid = 1'b0;
        end else if (r) begin
            m_fetch_pc   = {rp[31:2], 2'b00};
            m_slot_valid = 1'b0;
        end else if (m_slot_valid && !w) begin
            m_slot_valid = 1'b1;
        end else if (exp_en) begin
            m_slot_valid = 1'b1;
            m_slot_pc    = m_fetch_pc;
            m_fetch_pc   = m_fetch_pc + 32'd4;
        end else begin
            m_slot_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        phase = "reset";
        repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);

        phase = "stream_stall";
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);

        phase = "redirect";
        step(1'b0, 1'b1, 1'b1, 32'h0000_4003);
        repeat (4) step(1'b0, 1'b1, 1'b0, 32'h0);

        phase = "hold_redirect";
        repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h0000_5008);
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);

        phase = "wrap";
        step(1'b0, 1'b1, 1'b1, 32'hffff_fffc);
        repeat (4) step(1'b0, 1'b1, 1'b0, 32'h0);

        phase = "reset_stall";
        repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);

        phase = "random";
        for (int i = 0; i < 500; i++) begin
            logic        rst_r;
            logic        w_r;
            logic        r_r;
            logic [31:0] rp_r;
            rst_r = ($urandom_range(0, 59) == 0);
            w_r   = ($urandom_range(0, 3) != 0);
            r_r   = ($urandom_range(0, 9) == 0);
            rp_r  = ($urandom_range(0, 3) == 0) ? (32'hffff_fff0 | 32'($urandom_range(0, 15)))
                                                 : $urandom();
            step(rst_r, w_r, r_r, rp_r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline. Sits directly upstream of the IF/ID pipeline register and feeds it.
- Owns the PC register and issues requests to a synchronous-read instruction memory with 1-cycle latency.
- Absorbs IF/ID stalls with a one-entry hold buffer. Applies branch/jump redirects from later stages.
- Presents pc/instruction/valid each cycle for IF/ID to sample.

Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset
- BUBBLE_INSTR, 32'hfedc_ba98, instruction/pc pattern driven when no valid fetch is presented (same pattern IF/ID loads on flush)

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- ifid_write  in  1  1 = IF/ID samples the presented fetch this edge; 0 = stall
- redirect_valid  in  1  taken branch/jump/jr this cycle
- redirect_pc  in  32  target; bits [1:0] ignored, forced to 00
- imem_en  out  1  instruction-memory read request this cycle
- imem_addr  out  32  word address of request (= pc_q)
- imem_rdata  in  32  data for the request issued in the previous cycle
- pc_out  out  32  pc of presented instruction
- instruction_out  out  32  presented instruction
- fetch_valid  out  1  presented pc/instruction is a real fetch

Behaviour:
- State: pc_q[31:0], resp_valid_q, resp_pc_q[31:0], hold_valid_q, hold_pc_q[31:0], hold_instr_q[31:0].
- Reset (synchronous, dominates everything):
  - pc_q=RESET_PC; resp_valid_q=0; hold_valid_q=0; hold_pc_q/hold_instr_q=BUBBLE_INSTR.
  - While reset is high: imem_en=0, fetch_valid=0, pc_out=instruction_out=BUBBLE_INSTR.
- Presented slot (combinational), priority order:
  - redirect_valid=1 -> bubble.
  - hold_valid_q -> hold_pc_q/hold_instr_q, valid=1.
  - resp_valid_q -> resp_pc_q/imem_rdata, valid=1.
  - otherwise -> bubble (fetch_valid=0, pc_out=instruction_out=BUBBLE_INSTR).
- out_valid = hold_valid_q | resp_valid_q.
- Issue: imem_en = !reset & !redirect_valid & (ifid_write | !out_valid). imem_addr = pc_q always.
- When imem_en: pc_q <= pc_q+4, with 32-bit wrap (32'hFFFF_FFFC -> 0). resp_valid_q <= 1; resp_pc_q <= pc_q.
- When !imem_en: resp_valid_q <= 0.
- Stall capture: resp_valid_q & !hold_valid_q & !ifid_write & !redirect_valid -> hold_valid_q<=1, hold_pc_q<=resp_pc_q, hold_instr_q<=imem_rdata. The imem_rdata value is captured because it is not guaranteed stable after that cycle.
- Hold release: hold_valid_q & ifid_write & !redirect_valid -> hold_valid_q<=0. A new request is issued the same cycle, so there is no bubble.
- Invariant: hold_valid_q and resp_valid_q are never both 1. A bench assertion is required.
- Redirect (when not in reset):
  - pc_q <= {redirect_pc[31:2],2'b00}; resp_valid_q<=0; hold_valid_q<=0.
  - No request that cycle. The wrong-path instruction is dropped.
  - First target fetch is issued the next cycle and presented the cycle after.
  - Redirect penalty = 2 bubbles from this stage; IF/ID flush is driven externally.
- Redirect concurrent with stall: redirect wins; hold is discarded.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values on that edge.
- Latency: request at cycle N -> presented at cycle N+1. First valid after reset deassert: pc_out=RESET_PC one cycle after the first imem_en.
- Throughput: 1 instruction/cycle with ifid_write held 1.

Decomposition:
- Shared package pipe_pkg:
  - RESET_PC_DEFAULT, BUBBLE_INSTR (32'hfedcba98), PC_STEP (32'd4).
  - Redirect/NPC op encodings shared with the ID/EX npcop field.
- One natural sub-module, fetch_skid_buffer: one-entry hold register plus presented-slot mux. Inputs resp valid/pc/data, ifid_write, redirect_valid. Outputs presented slot and out_valid.
- PC register and issue logic stay in fetch_stage.

Test Plan:
- Reset release, ifid_write=1, imem returns mem[pc]:
  - imem_addr sequence is 3000,3004,3008.
  - pc_out is 3000,3004,3008 from one cycle later, with fetch_valid=1.
  - Outputs are BUBBLE while reset is high.
- Stall 3 cycles while 3004 is presented:
  - imem_en=0 during the stall; pc_out/instruction_out hold 3004/mem[3004].
  - imem_rdata is driven to garbage during the stall with no effect on the output.
  - On release, 3008 follows with no gap.
- Redirect to 32'h0000_4003 while streaming:
  - That cycle fetch_valid=0 and the output is BUBBLE.
  - Next cycle imem_addr=4000; following cycle pc_out=4000.
  - No wrong-path pc ever has fetch_valid=1.
- Redirect during an active hold (ifid_write=0): hold is dropped; next presented valid pc = target.
- PC wrap: redirect to FFFF_FFFC with no stall -> imem_addr FFFF_FFFC, then 0000_0000.
- Reset asserted during a stall with hold_valid=1 -> next cycle all outputs are BUBBLE and pc_q=RESET_PC. Random stall/redirect run with the hold/resp exclusivity assertion held throughout.
